// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Sequential instruction fetch feeding a 2-entry queue toward decode.
//   Fetch runs from RESET_PC in 4-byte steps until fpc reaches IMEM_BYTES, then
//   halts. A redirect flushes the queue and restarts fetch at a word-aligned
//   target, including from the halted state.
// Ports
//   clk, reset          rising-edge clock, async active-high reset
//   imem_pc/imem_instr  combinational instruction memory read (imem_pc = fpc)
//   redirect_valid/_pc  one-cycle redirect request and its target
//   dec_ready           decode accepts the head entry this cycle
//   if_valid/_instr/_pc queue head presented to decode (zeros when empty)
//   halted              fetch stopped at IMEM_BYTES and the queue is drained
module instr_fetch_unit #(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter int          IMEM_BYTES = 32
) (
    input  logic        clk,
    input  logic        reset,
    output logic [63:0] imem_pc,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    input  logic        dec_ready,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [63:0] if_pc,
    output logic        halted
);
    localparam logic [63:0] IMEM_END = 64'(IMEM_BYTES);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HALT} state_t;

    state_t      state_q, state_d;
    logic [63:0] fpc_q, fpc_d;
    logic [1:0]  count_q, count_d;
    logic [63:0] pc0_q, pc0_d, pc1_q, pc1_d;
    logic [31:0] ins0_q, ins0_d, ins1_q, ins1_d;
    logic        if_valid_q, if_valid_d;
    logic        halted_q, halted_d;

    logic at_end, pop, push;

    // The end-of-memory check looks at fpc before any push, so the word at
    // IMEM_BYTES is never fetched.
    assign at_end = (fpc_q >= IMEM_END);
    assign pop    = if_valid_q && dec_ready && !redirect_valid;
    assign push   = !redirect_valid && (state_q == S_FETCH) && !at_end &&
                    ((count_q != 2'd2) || pop);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (redirect_valid) begin
            state_d = S_FETCH;
        end else begin
            case (state_q)
                S_IDLE:  state_d = S_FETCH;
                S_FETCH: if (at_end) state_d = S_HALT;
                S_HALT:  state_d = S_HALT;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Datapath / output next values
    always_comb begin
        fpc_d   = fpc_q;
        count_d = count_q;
        pc0_d   = pc0_q;
        ins0_d  = ins0_q;
        pc1_d   = pc1_q;
        ins1_d  = ins1_q;
        if (redirect_valid) begin
            // Flush: whatever sits at the head is dropped even if decode was ready.
            fpc_d   = {redirect_pc[63:2], 2'b00};
            count_d = 2'd0;
            pc0_d   = '0;
            ins0_d  = '0;
            pc1_d   = '0;
            ins1_d  = '0;
        end else begin
            if (push) fpc_d = fpc_q + 64'd4;
            case ({push, pop})
                2'b01: begin
                    pc0_d   = pc1_q;
                    ins0_d  = ins1_q;
                    pc1_d   = '0;
                    ins1_d  = '0;
                    count_d = count_q - 2'd1;
                end
                2'b10: begin
                    if (count_q == 2'd0) begin
                        pc0_d  = fpc_q;
                        ins0_d = imem_instr;
                    end else begin
                        pc1_d  = fpc_q;
                        ins1_d = imem_instr;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        pc0_d  = fpc_q;
                        ins0_d = imem_instr;
                    end else begin
                        pc0_d  = pc1_q;
                        ins0_d = ins1_q;
                        pc1_d  = fpc_q;
                        ins1_d = imem_instr;
                    end
                end
                default: ;
            endcase
        end
        if_valid_d = (count_d != 2'd0);
        halted_d   = (state_d == S_HALT) && (count_d == 2'd0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fpc_q      <= RESET_PC;
            count_q    <= 2'd0;
            pc0_q      <= '0;
            ins0_q     <= '0;
            pc1_q      <= '0;
            ins1_q     <= '0;
            if_valid_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            fpc_q      <= fpc_d;
            count_q    <= count_d;
            pc0_q      <= pc0_d;
            ins0_q     <= ins0_d;
            pc1_q      <= pc1_d;
            ins1_q     <= ins1_d;
            if_valid_q <= if_valid_d;
            halted_q   <= halted_d;
        end
    end

    assign imem_pc  = fpc_q;
    assign if_valid = if_valid_q;
    assign if_instr = ins0_q;
    assign if_pc    = pc0_q;
    assign halted   = halted_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a per-cycle vector table covering
// streaming, halt at end of memory, redirects (aligned, misaligned, while full)
// and backpressure, plus hand sequences for reset-time corner cases.
module tb_instr_fetch_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] imem_pc;
    logic [31:0] imem_instr;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        dec_ready = 1'b0;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [63:0] if_pc;
    logic        halted;

    int total  = 0;
    int passed = 0;

    logic [31:0] mem [8];

    instr_fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .imem_pc        (imem_pc),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_ready      (dec_ready),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_at(input logic [63:0] pc);
        if (pc < 64'd32) return mem[pc[4:2]];
        return 32'hDEAD_BEEF;
    endfunction

    assign imem_instr = instr_at(imem_pc);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check_out(input string tag, input logic ev, input logic [63:0] epc,
                             input logic [63:0] eimem, input logic eh);
        chk({tag, " if_valid"}, 64'(if_valid), 64'(ev));
        chk({tag, " if_pc"},    if_pc, epc);
        chk({tag, " if_instr"}, 64'(if_instr), ev ? 64'(instr_at(epc)) : 64'd0);
        chk({tag, " imem_pc"},  imem_pc, eimem);
        chk({tag, " halted"},   64'(halted), 64'(eh));
    endtask

    // Drive inputs, take one edge, check 1 time unit later.
    task automatic step(input string tag, input logic dr, input logic rv, input logic [63:0] rpc,
                        input logic ev, input logic [63:0] epc, input logic [63:0] eimem,
                        input logic eh);
        dec_ready      = dr;
        redirect_valid = rv;
        redirect_pc    = rpc;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        check_out(tag, ev, epc, eimem, eh);
    endtask

    task automatic do_reset(input string tag);
        dec_ready      = 1'b0;
        redirect_valid = 1'b0;
        reset          = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_out({tag, " reset"}, 1'b0, 64'd0, 64'd0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        logic        dr;
        logic        rv;
        logic [63:0] rpc;
        logic        ev;
        logic [63:0] epc;
        logic [63:0] eimem;
        logic        eh;
    } vec_t;

    vec_t vecs [20];

    initial begin
        mem[0] = 32'h0094_0333;
        mem[1] = 32'h4139_03b3;
        for (int i = 2; i < 8; i++) mem[i] = 32'h1000_0013 + 32'(i << 7);

        //            dr    rv    rpc     ev    epc     imem    halt
        vecs[0]  = '{1'b1, 1'b0, 64'h0,  1'b0, 64'h0,  64'h0,  1'b0}; // IDLE cycle
        for (int k = 1; k <= 8; k++)
            vecs[k] = '{1'b1, 1'b0, 64'h0, 1'b1, 64'(4*(k-1)), 64'(4*k), 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 64'h0,  1'b0, 64'h0,  64'h20, 1'b1}; // drained, halted
        vecs[10] = '{1'b1, 1'b0, 64'h0,  1'b0, 64'h0,  64'h20, 1'b1};
        vecs[11] = '{1'b1, 1'b1, 64'h0,  1'b0, 64'h0,  64'h0,  1'b0}; // restart from halt
        vecs[12] = '{1'b1, 1'b0, 64'h0,  1'b1, 64'h0,  64'h4,  1'b0};
        vecs[13] = '{1'b1, 1'b0, 64'h0,  1'b1, 64'h4,  64'h8,  1'b0};
        vecs[14] = '{1'b1, 1'b1, 64'hE,  1'b0, 64'h0,  64'hC,  1'b0}; // misaligned target
        vecs[15] = '{1'b1, 1'b0, 64'h0,  1'b1, 64'hC,  64'h10, 1'b0};
        vecs[16] = '{1'b0, 1'b0, 64'h0,  1'b1, 64'hC,  64'h14, 1'b0}; // fills to 2
        vecs[17] = '{1'b0, 1'b0, 64'h0,  1'b1, 64'hC,  64'h14, 1'b0}; // full, fpc holds
        vecs[18] = '{1'b1, 1'b1, 64'h10, 1'b0, 64'h0,  64'h10, 1'b0}; // redirect while full
        vecs[19] = '{1'b1, 1'b0, 64'h0,  1'b1, 64'h10, 64'h14, 1'b0};

        do_reset("A");
        for (int i = 0; i < 20; i++)
            step($sformatf("vec%0d", i), vecs[i].dr, vecs[i].rv, vecs[i].rpc,
                 vecs[i].ev, vecs[i].epc, vecs[i].eimem, vecs[i].eh);

        // Backpressure from reset, then release: pc 0, 4, 8 in order.
        do_reset("B");
        step("bp0", 1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 64'h0,  1'b0);
        step("bp1", 1'b0, 1'b0, 64'h0, 1'b1, 64'h0, 64'h4,  1'b0);
        step("bp2", 1'b0, 1'b0, 64'h0, 1'b1, 64'h0, 64'h8,  1'b0);
        step("bp3", 1'b0, 1'b0, 64'h0, 1'b1, 64'h0, 64'h8,  1'b0);
        step("bp4", 1'b1, 1'b0, 64'h0, 1'b1, 64'h4, 64'hC,  1'b0);
        step("bp5", 1'b1, 1'b0, 64'h0, 1'b1, 64'h8, 64'h10, 1'b0);
        step("bp6", 1'b1, 1'b0, 64'h0, 1'b1, 64'hC, 64'h14, 1'b0);

        // Asynchronous reset mid-stream with one entry (pc 8) queued.
        do_reset("C");
        step("ms0", 1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 64'h0, 1'b0);
        step("ms1", 1'b1, 1'b0, 64'h0, 1'b1, 64'h0, 64'h4, 1'b0);
        step("ms2", 1'b1, 1'b0, 64'h0, 1'b1, 64'h4, 64'h8, 1'b0);
        step("ms3", 1'b1, 1'b0, 64'h0, 1'b1, 64'h8, 64'hC, 1'b0);
        #2 reset = 1'b1;
        #1 check_out("async", 1'b0, 64'h0, 64'h0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        step("ms4", 1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 64'h0, 1'b0);
        step("ms5", 1'b1, 1'b0, 64'h0, 1'b1, 64'h0, 64'h4, 1'b0);

        // Redirect during the IDLE cycle still proceeds to fetch next cycle.
        do_reset("D");
        step("idl0", 1'b1, 1'b1, 64'h8, 1'b0, 64'h0, 64'h8, 1'b0);
        step("idl1", 1'b1, 1'b0, 64'h0, 1'b1, 64'h8, 64'hC, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
